// File: rtl/dm_access_seq_pkg.sv
// Shared DMType codes, sequencer state encoding and byte-count helper
// for the byte-serial data-memory access sequencer.
package dm_access_seq_pkg;

    localparam logic [2:0] dm_word              = 3'b000;
    localparam logic [2:0] dm_halfword          = 3'b001;
    localparam logic [2:0] dm_halfword_unsigned = 3'b010;
    localparam logic [2:0] dm_byte              = 3'b011;
    localparam logic [2:0] dm_byte_unsigned     = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    // Zero marks an illegal DMType code.
    function automatic logic [2:0] byte_count(input logic [2:0] t);
        logic [2:0] n;
        case (t)
            dm_word:              n = 3'd4;
            dm_halfword:          n = 3'd2;
            dm_halfword_unsigned: n = 3'd2;
            dm_byte:              n = 3'd1;
            dm_byte_unsigned:     n = 3'd1;
            default:              n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Combinational load extender: raw little-endian bytes {b3,b2,b1,b0}
// to the 32-bit load result selected by the DMType code.
module dm_load_ext
    import dm_access_seq_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [2:0]  dm_type,
    output logic [31:0] data
);

    always_comb begin
        data = raw;
        case (dm_type)
            dm_halfword:
                data = {{16{raw[15]}}, raw[15:0]};
            dm_halfword_unsigned:
                data = {16'b0, raw[15:0]};
            dm_byte:
                data = {{24{raw[7]}}, raw[7:0]};
            dm_byte_unsigned:
                data = {24'b0, raw[7:0]};
            default:
                data = raw;
        endcase
    end

endmodule

// File: rtl/dm_access_seq.sv
// MEM-stage initiator for a byte-wide data memory: serialises one
// load/store into byte cycles, stalls the pipe and assembles loads.
module dm_access_seq
    import dm_access_seq_pkg::*;
#(
    parameter int AW = 9,
    parameter int DW = 32
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic [2:0]    req_type,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_din,
    input  logic [7:0]    mem_dout,
    output logic          stall,
    output logic          done,
    output logic [DW-1:0] rdata,
    output logic          err
);

    state_t          state;
    logic            we_l;
    logic [AW-1:0]   addr_l;
    logic [DW-1:0]   wdata_l;
    logic [2:0]      type_l;
    logic [1:0]      cnt;
    logic [1:0]      last;
    logic [3:0][7:0] lanes;
    logic [3:0][7:0] lanes_nxt;
    logic [DW-1:0]   ext_data;
    logic [2:0]      req_n;

    assign req_n = byte_count(req_type);

    // The final byte is merged here so rdata can load on the DONE edge.
    always_comb begin
        lanes_nxt = lanes;
        lanes_nxt[cnt] = mem_dout;
    end

    dm_load_ext u_ext (
        .raw     (lanes_nxt),
        .dm_type (type_l),
        .data    (ext_data)
    );

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        stall    = 1'b0;
        case (state)
            IDLE: stall = req & ~rst;
            XFER: begin
                stall    = 1'b1;
                mem_we   = we_l;
                mem_addr = addr_l + AW'(cnt);
                mem_din  = wdata_l[{cnt, 3'b000} +: 8];
            end
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            we_l    <= 1'b0;
            addr_l  <= '0;
            wdata_l <= '0;
            type_l  <= dm_word;
            cnt     <= '0;
            last    <= '0;
            lanes   <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        we_l    <= req_we;
                        addr_l  <= req_addr;
                        wdata_l <= req_wdata;
                        type_l  <= req_type;
                        cnt     <= '0;
                        last    <= 2'(req_n - 3'd1);
                        lanes   <= '0;
                        if (req_n == 3'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state <= XFER;
                        end
                    end
                end
                XFER: begin
                    if (!we_l)
                        lanes <= lanes_nxt;
                    if (cnt == last) begin
                        state <= DONE;
                        done  <= 1'b1;
                        if (!we_l)
                            rdata <= ext_data;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_seq.sv
// Directed bench for dm_access_seq with a transaction-level model of
// the byte-serial schedule, load extension and a behavioural memory.
module tb_dm_access_seq;

    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic [2:0]    req_type;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic [7:0]    mem_dout;
    logic          stall;
    logic          done;
    logic [31:0]   rdata;
    logic          err;

    logic [7:0] dm [0:511];
    logic          poke;
    logic [AW-1:0] poke_a;
    logic [7:0]    poke_d;

    int vectors = 0;
    int miscompares = 0;

    bit            chk_on = 1'b0;
    logic          e_stall, e_we, e_done, e_err;
    logic [AW-1:0] e_addr;
    logic [7:0]    e_din;
    logic [31:0]   e_rdata;

    always #5 clk = ~clk;

    dm_access_seq #(.AW(AW), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_type  (req_type),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .stall     (stall),
        .done      (done),
        .rdata     (rdata),
        .err       (err)
    );

    assign mem_dout = dm[mem_addr];

    always @(posedge clk) begin
        if (mem_we)
            dm[mem_addr] <= mem_din;
        if (poke)
            dm[poke_a] <= poke_d;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("stall", 32'(stall), 32'(e_stall));
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("done", 32'(done), 32'(e_done));
            chk("err", 32'(err), 32'(e_err));
            chk("rdata", rdata, e_rdata);
            if (e_we === 1'b1) begin
                chk("mem_addr", 32'(mem_addr), 32'(e_addr));
                chk("mem_din", 32'(mem_din), 32'(e_din));
            end
        end
    end

    function automatic int nbytes(input logic [2:0] t);
        case (t)
            3'b000: return 4;
            3'b001, 3'b010: return 2;
            3'b011, 3'b100: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [AW-1:0] a,
                                               input logic [2:0] t);
        logic [7:0] b [4];
        logic [15:0] h;
        logic signed [31:0] s;
        for (int k = 0; k < 4; k++)
            b[k] = dm[AW'(int'(a) + k)];
        h = {b[1], b[0]};
        case (t)
            3'b000: return {b[3], b[2], b[1], b[0]};
            3'b001: begin s = $signed(h); return s; end
            3'b010: return 32'(h);
            3'b011: begin s = $signed(b[0]); return s; end
            3'b100: return 32'(b[0]);
            default: return 32'h0;
        endcase
    endfunction

    task automatic poke_byte(input logic [AW-1:0] a, input logic [7:0] d);
        poke = 1'b1;
        poke_a = a;
        poke_d = d;
        @(posedge clk);
        #1;
        poke = 1'b0;
    endtask

    // Starts in an IDLE cycle, 1 time unit after a rising edge.
    task automatic access(input logic we, input logic [AW-1:0] a,
                          input logic [31:0] wd, input logic [2:0] t,
                          input bit noise, input bit keep);
        int n;
        logic [31:0] ld;
        n = nbytes(t);
        ld = model_load(a, t);
        req = 1'b1;
        req_we = we;
        req_addr = a;
        req_wdata = wd;
        req_type = t;
        e_stall = 1'b1;
        e_we = 1'b0;
        e_done = 1'b0;
        e_err = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (noise) begin
                req = 1'($urandom_range(0, 1));
                req_we = 1'($urandom_range(0, 1));
                req_addr = AW'($urandom);
                req_type = 3'($urandom_range(0, 7));
            end else begin
                req = 1'b0;
            end
            e_stall = 1'b1;
            e_we = we;
            e_addr = AW'(int'(a) + k);
            e_din = wd[8*k +: 8];
        end
        @(posedge clk);
        #1;
        req = keep;
        req_we = we;
        req_addr = a;
        req_type = t;
        e_stall = 1'b0;
        e_we = 1'b0;
        e_done = 1'b1;
        e_err = (n == 0);
        if (!we && n != 0)
            e_rdata = ld;
        @(posedge clk);
        #1;
        req = keep;
        e_done = 1'b0;
        e_err = 1'b0;
        e_stall = keep;
    endtask

    initial begin
        rst = 1'b1;
        req = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_type = 3'b000;
        poke = 1'b0;
        poke_a = '0;
        poke_d = '0;
        #1;
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        e_stall = 1'b0;
        e_we = 1'b0;
        e_done = 1'b0;
        e_err = 1'b0;
        e_addr = '0;
        e_din = '0;
        e_rdata = 32'h0;
        chk_on = 1'b1;
        @(posedge clk);
        #1;

        access(1'b1, 9'h010, 32'hDEADBEEF, 3'b000, 1'b0, 1'b0);
        chk("st_b0", 32'(dm[9'h010]), 32'hEF);
        chk("st_b1", 32'(dm[9'h011]), 32'hBE);
        chk("st_b2", 32'(dm[9'h012]), 32'hAD);
        chk("st_b3", 32'(dm[9'h013]), 32'hDE);
        chk("st_rdata_kept", rdata, 32'h0);

        poke_byte(9'h020, 8'h80);
        access(1'b0, 9'h020, 32'h0, 3'b011, 1'b0, 1'b0);
        chk("lb_lit", rdata, 32'hFFFFFF80);
        access(1'b0, 9'h020, 32'h0, 3'b100, 1'b0, 1'b0);
        chk("lbu_lit", rdata, 32'h00000080);

        poke_byte(9'd511, 8'h34);
        poke_byte(9'd0, 8'h92);
        access(1'b0, 9'd511, 32'h0, 3'b001, 1'b0, 1'b0);
        chk("lh_wrap_lit", rdata, 32'hFFFF9234);
        access(1'b0, 9'd511, 32'h0, 3'b010, 1'b0, 1'b0);
        chk("lhu_wrap_lit", rdata, 32'h00009234);

        access(1'b0, 9'h010, 32'h0, 3'b000, 1'b1, 1'b1);
        chk("lw_lit", rdata, 32'hDEADBEEF);
        access(1'b0, 9'h011, 32'h0, 3'b001, 1'b0, 1'b0);
        chk("lh_b2b_lit", rdata, 32'hFFFFADBE);

        access(1'b0, 9'h010, 32'h0, 3'b111, 1'b0, 1'b0);
        chk("illegal_rdata_kept", rdata, 32'hFFFFADBE);

        access(1'b1, 9'd510, 32'hA1B2C3D4, 3'b000, 1'b0, 1'b0);
        chk("st_wrap_hi", 32'(dm[9'd511]), 32'hC3);
        chk("st_wrap_lo", 32'(dm[9'd1]), 32'hA1);

        poke_byte(9'h040, 8'h01);
        poke_byte(9'h041, 8'h02);
        poke_byte(9'h042, 8'hAA);
        poke_byte(9'h043, 8'h55);
        chk_on = 1'b0;
        req = 1'b1;
        req_we = 1'b1;
        req_addr = 9'h040;
        req_wdata = 32'h11223344;
        req_type = 3'b000;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("t4_we_before_rst", 32'(mem_we), 32'h1);
        rst = 1'b1;
        #1;
        chk("t4_stall", 32'(stall), 32'h0);
        chk("t4_mem_we", 32'(mem_we), 32'h0);
        chk("t4_mem_addr", 32'(mem_addr), 32'h0);
        chk("t4_mem_din", 32'(mem_din), 32'h0);
        chk("t4_done", 32'(done), 32'h0);
        chk("t4_err", 32'(err), 32'h0);
        chk("t4_rdata", rdata, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t4_dm40", 32'(dm[9'h040]), 32'h44);
        chk("t4_dm41", 32'(dm[9'h041]), 32'h33);
        chk("t4_dm42", 32'(dm[9'h042]), 32'hAA);
        chk("t4_dm43", 32'(dm[9'h043]), 32'h55);
        e_stall = 1'b0;
        e_we = 1'b0;
        e_done = 1'b0;
        e_err = 1'b0;
        e_rdata = 32'h0;
        chk_on = 1'b1;
        @(posedge clk);
        #1;
        access(1'b0, 9'h040, 32'h0, 3'b000, 1'b0, 1'b0);
        chk("t4_lw_lit", rdata, 32'h55AA3344);

        @(posedge clk);
        #1;
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
